led_scan_mux: RTL

- Downstream consumer of the Display_Hello text/scroll generator.
- Takes the packed per-digit segment array `LED` and time-multiplexes it onto one 8-bit segment bus with a one-hot digit select.
- Drives a physical multi-digit 7-segment board (7 segments + DP).
- Snapshots the array once per frame, so a display update cannot tear mid-scan.

---
 rtl/led_scan_mux.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/led_scan_mux.sv
// led_scan_mux
//    Time-multiplexes a packed array of 7-segment patterns onto a single
//    8-bit segment bus with a one-hot digit select. The array is copied
//    into a shadow register once per frame (LOAD), so an update to LED
//    never tears a frame that is already being scanned.
//
//    Build option: define SCAN_ACTIVE_LOW_EN to drive seg and dig_sel
//    inverted (common-anode boards). frame_done and busy stay active-high.
//
// Ports
//    clk         system clock, rising edge
//    rst         synchronous active-high reset
//    en          scan enable, sampled in IDLE and at frame end only
//    LED         per-digit pattern, bit0=a .. bit6=g, bit7=DP
//    seg         segment drive for the selected digit (registered)
//    dig_sel     one-hot digit select (registered)
//    frame_done  one-cycle pulse after the last digit of a frame
//    busy        high while a frame is in progress
//
// state | meaning
// IDLE  | outputs off, waiting for en
// LOAD  | capture LED into shadow, restart at digit 0
// SHOW  | digit idx lit for pDIV cycles
// BLANK | all digits off for pBLANK cycles (anti-ghosting)

module led_scan_mux #(
   parameter int pNO_LED = 8,
   parameter int pDIV    = 4,
   parameter int pBLANK  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [pNO_LED-1:0][7:0] LED,
   output logic [7:0]              seg,
   output logic [pNO_LED-1:0]      dig_sel,
   output logic                    frame_done,
   output logic                    busy
);

`ifdef SCAN_ACTIVE_LOW_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   localparam int MAXD = (pDIV > pBLANK) ? pDIV : pBLANK;
   localparam int IW   = $clog2(pNO_LED);
   localparam int CW   = $clog2(MAXD + 1);

   localparam logic [IW-1:0] LAST   = IW'(pNO_LED - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(pDIV - 1);
   localparam logic [CW-1:0] BLK_LD = CW'(pBLANK - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHOW  = 2'd2,
      BLANK = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [pNO_LED-1:0][7:0] shadow;
   logic                    load;
   logic                    advance;
   logic                    done_nxt;
   logic [7:0]              seg_c;
   logic [pNO_LED-1:0]      dig_c;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      load      = 1'b0;
      advance   = 1'b0;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (en) state_nxt = LOAD;
         end
         LOAD: begin
            load      = 1'b1;
            idx_nxt   = '0;
            cnt_nxt   = DIV_LD;
            state_nxt = SHOW;
         end
         SHOW: begin
            // Dwell is a down-counter; terminal count is zero.
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else if (pBLANK > 0) begin
               cnt_nxt   = BLK_LD;
               state_nxt = BLANK;
            end else begin
               advance = 1'b1;
            end
         end
         BLANK: begin
            if (cnt != '0) cnt_nxt = cnt - CW'(1);
            else           advance = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      if (advance) begin
         if (idx != LAST) begin
            idx_nxt   = idx + IW'(1);
            cnt_nxt   = DIV_LD;
            state_nxt = SHOW;
         end else begin
            // Frame end: en is only looked at here, so a frame never truncates.
            done_nxt  = 1'b1;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = en ? LOAD : IDLE;
         end
      end
   end

   // Display drive decoded from the current state; registered below, so the
   // board sees a digit one cycle after the FSM enters SHOW.
   always_comb begin
      seg_c = {8{INV}};
      dig_c = {pNO_LED{INV}};
      if (state == SHOW) begin
         seg_c = shadow[idx] ^ {8{INV}};
         dig_c = ({{(pNO_LED-1){1'b0}}, 1'b1} << idx) ^ {pNO_LED{INV}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         shadow     <= '0;
         seg        <= {8{INV}};
         dig_sel    <= {pNO_LED{INV}};
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         if (load) shadow <= LED;
         seg        <= seg_c;
         dig_sel    <= dig_c;
         frame_done <= done_nxt;
         busy       <= (state_nxt != IDLE);
      end
   end

endmodule
